// File: rtl/mem_port_arbiter.sv
// Arbitrates one negedge-clocked single-port RAM between instruction fetch and
// data load/store. Data has priority, and a saturating counter bounds fetch starvation.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int D_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] DCNT_MAX = 4'(D_MAX);

    logic [1:0]        state_reg, state_next;
    logic              sel_reg, sel_next;
    logic [3:0]        dcnt_reg, dcnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              we_reg, we_next;
    logic              busy_reg;
    logic [1:0]        ack_reg, ack_next;     // bit 0 = fetch, bit 1 = data
    logic [DATA_W-1:0] rdata_reg [2];
    logic              grant_d;

    // Fetch only overrides a pending data request once data has won D_MAX times in a row.
    assign grant_d = d_req && !(i_req && dcnt_reg == DCNT_MAX);

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        dcnt_next  = dcnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        we_next    = we_reg;
        ack_next   = '0;
        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    sel_next   = 1'b1;
                    addr_next  = d_addr;
                    wdata_next = d_wdata;
                    we_next    = d_we;
                    state_next = ACC;
                    if (!i_req)
                        dcnt_next = '0;
                    else if (dcnt_reg != DCNT_MAX)
                        dcnt_next = dcnt_reg + 4'd1;
                end else if (i_req) begin
                    sel_next   = 1'b0;
                    addr_next  = i_addr;
                    wdata_next = '0;
                    we_next    = 1'b0;
                    state_next = ACC;
                    dcnt_next  = '0;
                end
            end
            ACC: begin
                ack_next[sel_reg] = 1'b1;
                we_next           = 1'b0;
                state_next        = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
            dcnt_reg  <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            ack_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            dcnt_reg  <= dcnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            we_reg    <= we_next;
            ack_reg   <= ack_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    // Read data is captured at the posedge closing ACC, into the granted port only.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk) begin
                if (rst)
                    rdata_reg[gi] <= '0;
                else if (state_reg == ACC && sel_reg == 1'(gi))
                    rdata_reg[gi] <= mem_q;
            end
        end
    endgenerate

    assign i_ack    = ack_reg[0];
    assign d_ack    = ack_reg[1];
    assign i_rdata  = rdata_reg[0];
    assign d_rdata  = rdata_reg[1];
    assign mem_addr = addr_reg;
    assign mem_d    = wdata_reg;
    assign mem_we   = we_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: negedge RAM model, expected-response queue and an ack monitor.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_ack, d_ack, mem_we, busy;
    logic [DW-1:0] i_rdata, d_rdata, mem_d, mem_q;
    logic [AW-1:0] mem_addr;

    int compared   = 0;
    int mismatched = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_MAX(DM)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: negedge write-enable, registered read returning pre-write contents.
    logic [DW-1:0] ram [256];
    logic          pl_en = 1'b0;
    logic [7:0]    pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    int            wr_count = 0;
    always @(negedge clk) begin
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_d;
            wr_count <= wr_count + 1;
        end
        mem_q <= ram[mem_addr[7:0]];
    end

    typedef struct {
        bit            port;   // 0 = fetch, 1 = data
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int i_acks = 0;
    int d_acks = 0;
    int we_cycles = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mem_we) we_cycles++;
        if (i_ack) i_acks++;
        if (d_ack) d_acks++;
        if (i_ack && d_ack) check("dual_ack", 1, 0);
        else if (i_ack || d_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {31'd0, d_ack}, 2);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", {31'd0, d_ack}, {31'd0, e.port});
                check("ack_rdata", d_ack ? d_rdata : i_rdata, e.data);
                $display("ack port=%0d data=%h", d_ack, d_ack ? d_rdata : i_rdata);
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [DW-1:0] v);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        @(negedge clk); #1;
        pl_en = 1'b0;
    endtask

    // One request held until its ack, then dropped; expectation pushed at issue.
    task automatic do_access(input bit port, input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [DW-1:0] expd);
        bit got = 0;
        exp_q.push_back('{port, expd});
        if (port) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
        else begin i_req = 1; i_addr = a; end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (port ? d_ack : i_ack) got = 1;
        end
        check("ack_timeout", {31'd0, got}, 1);
        @(posedge clk); #1;
        if (port) d_req = 0; else i_req = 0;
    endtask

    initial begin
        int wr0, we0, da0, dcyc, icyc, dbefore;
        bit seen_i, done;
        rst = 1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        preload(8'h04, 32'h0000F137);
        preload(8'h10, 32'h11111111);
        preload(8'h30, 32'h33333333);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_mem_we", {31'd0, mem_we}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_d", mem_d, 0);
        check("rst_acks", {30'd0, i_ack, d_ack}, 0);
        check("rst_rdata", i_rdata | d_rdata, 0);

        // Fetch only, cycle-exact
        @(posedge clk); #1;
        i_addr = 32'h04; i_req = 1;
        exp_q.push_back('{1'b0, 32'h0000F137});
        @(negedge clk);
        check("f_c0_busy", {31'd0, busy}, 0);
        @(negedge clk);
        check("f_c1_addr", mem_addr, 32'h04);
        check("f_c1_we", {31'd0, mem_we}, 0);
        check("f_c1_busy", {31'd0, busy}, 1);
        check("f_c1_ack", {31'd0, i_ack}, 0);
        @(negedge clk);
        check("f_c2_ack", {31'd0, i_ack}, 1);
        check("f_c2_busy", {31'd0, busy}, 1);
        @(posedge clk); #1;
        i_req = 0;
        @(negedge clk);
        check("f_c3_ack", {31'd0, i_ack}, 0);
        check("f_c3_busy", {31'd0, busy}, 0);

        // Store then load
        wr0 = wr_count; we0 = we_cycles;
        do_access(1, 1, 32'h10, 32'hDEADBEEF, 32'h11111111);
        check("st_writes", 32'(wr_count - wr0), 1);
        check("st_we_cycles", 32'(we_cycles - we0), 1);
        do_access(1, 0, 32'h10, 32'h0, 32'hDEADBEEF);

        // Simultaneous requests: data at cycle 2, fetch at cycle 5
        @(posedge clk); #1;
        exp_q.push_back('{1'b1, 32'hDEADBEEF});
        exp_q.push_back('{1'b0, 32'h0000F137});
        d_we = 0; d_addr = 32'h10; d_req = 1;
        i_addr = 32'h04; i_req = 1;
        dcyc = -1; icyc = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d_ack) dcyc = k;
            if (i_ack) icyc = k;
            @(posedge clk); #1;
            if (dcyc == k) d_req = 0;
            if (icyc == k) i_req = 0;
        end
        check("sim_d_cycle", 32'(dcyc), 2);
        check("sim_i_cycle", 32'(icyc), 5);

        // Starvation guard: D_MAX data acks, one fetch, then data resumes
        for (int k = 0; k < 5; k++) exp_q.push_back('{1'b1, 32'hDEADBEEF});
        exp_q.insert(4, '{1'b0, 32'h0000F137});
        d_we = 0; d_addr = 32'h10; d_req = 1;
        i_addr = 32'h04; i_req = 1;
        seen_i = 0; done = 0; dbefore = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (i_ack) seen_i = 1;
            if (d_ack && seen_i) done = 1;
            if (d_ack && !seen_i) dbefore++;
            @(posedge clk); #1;
            if (seen_i) i_req = 0;
            if (done) d_req = 0;
        end
        d_req = 0; i_req = 0;
        check("starve_d_before_i", 32'(dbefore), DM);
        check("starve_done", {31'd0, done}, 1);

        // Reset while a load sits in ACC: no ack, then clean reissue
        da0 = d_acks;
        d_we = 0; d_addr = 32'h10; d_req = 1;
        @(posedge clk); #1;           // cycle 1: ACC
        rst = 1; d_req = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rst_mid_busy", {31'd0, busy}, 0);
        check("rst_mid_we", {31'd0, mem_we}, 0);
        check("rst_mid_ack", {31'd0, d_ack}, 0);
        repeat (3) @(negedge clk);
        check("rst_mid_no_ack", 32'(d_acks - da0), 0);
        @(posedge clk); #1;
        do_access(1, 0, 32'h10, 32'h0, 32'hDEADBEEF);

        // Hold-through-ack store: one ack, one write
        wr0 = wr_count; da0 = d_acks;
        do_access(1, 1, 32'h30, 32'h5A5A5A5A, 32'h33333333);
        repeat (4) @(negedge clk);
        check("hold_writes", 32'(wr_count - wr0), 1);
        check("hold_acks", 32'(d_acks - da0), 1);
        @(posedge clk); #1;
        do_access(1, 0, 32'h30, 32'h0, 32'h5A5A5A5A);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port RAM (negedge-clocked, registered read, write-enable `menable`) between the instruction-fetch requester and the data load/store requester.
- Runs on the posedge core clock.
- Drives the RAM address, data and write enable from registers.
- Captures read data and returns it to the granted requester with a one-cycle ack pulse.
- The data port has priority; a starvation guard guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width passed unchanged to the RAM (no byte/word translation).
- DATA_W, 32, data width.
- D_MAX, 4, maximum consecutive data grants while a fetch is pending; range 1..15.

Ports:
- clk  in  1  core clock, posedge; the RAM uses the negedge of the same clock.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle.
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse; d_rdata valid in the same cycle.
- d_rdata  out  DATA_W  load data.
- mem_addr  out  ADDR_W  to RAM addr.
- mem_d  out  DATA_W  to RAM d.
- mem_we  out  1  to RAM menable.
- mem_q  in  DATA_W  from RAM q.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state and outputs are posedge registers.
- Reset values: state = IDLE; i_ack = d_ack = 0; mem_we = 0; mem_addr = 0; mem_d = 0; i_rdata = d_rdata = 0; dcnt = 0; busy = 0.
- Three states: IDLE, ACC, RESP. A register `sel` records the granted port (0 = fetch, 1 = data).
- IDLE, arbitration:
  - If d_req and not (i_req and dcnt == D_MAX): grant data.
  - Else if i_req: grant fetch.
  - Else stay in IDLE.
- On grant:
  - Load mem_addr from the granted address, mem_d = d_wdata (data grant) or 0 (fetch grant), and set sel.
  - mem_we = d_we for a data grant, 0 for a fetch grant.
  - Next state is ACC.
- ACC:
  - The RAM samples on the mid-cycle negedge; mem_q is valid by the closing posedge.
  - At that posedge: capture mem_q into i_rdata or d_rdata per sel, assert the matching ack, force mem_we = 0. Next state is RESP.
- RESP:
  - The ack is high for exactly this cycle and clears at the closing posedge. Next state is IDLE.
  - No arbitration happens in RESP, so a req still high during its ack cycle is never re-granted.
- Latency and throughput:
  - Grant seen in IDLE at cycle N; mem signals driven in N+1; ack in N+2.
  - A new request may be raised in N+3; throughput is one access per 3 cycles.
- mem_we is high only in ACC, so there is exactly one RAM write per store.
- Store ack: d_ack pulses with d_rdata = pre-write RAM contents at d_addr (the RAM reads old data). Requesters ignore d_rdata on stores.
- Starvation counter dcnt (4 bits, saturating at D_MAX):
  - Data grant while i_req is high: increment.
  - Any fetch grant: clear to 0.
  - Data grant with i_req low: clear to 0.
- Simultaneous requests: data wins unless dcnt == D_MAX, in which case fetch wins and dcnt clears.
- Requests arriving during ACC/RESP wait in IDLE arbitration; nothing is queued internally.
- Dropping req before ack is illegal; the access completes regardless and the ack is still pulsed.
- Reset mid-operation, in any state:
  - Next state is IDLE; both acks are low and mem_we is low from the next cycle.
  - The in-flight access is abandoned with no ack; requesters reissue.
  - A store in ACC when rst is sampled may or may not have been written (the RAM negedge precedes the posedge); software treats it as lost.
- Address and data widths are passed through unmodified; no alignment checks.

Test Plan:
- Fetch only: preload RAM[0x04] = 0x0000F137; i_req = 1, i_addr = 0x04 in cycle 0 -> mem_addr = 0x04, mem_we = 0 in cycle 1; i_ack = 1 with i_rdata = 0x0000F137 in cycle 2 only; busy high in cycles 1-2.
- Store then load: d_req = 1, d_we = 1, d_addr = 0x10, d_wdata = 0xDEADBEEF -> mem_we high exactly one cycle, then d_ack. Then d_we = 0, same address -> d_rdata = 0xDEADBEEF.
- Simultaneous requests: i_req and d_req both high in the same cycle with dcnt = 0 -> data granted first (d_ack at cycle 2); fetch granted next IDLE (i_ack at cycle 5).
- Starvation, D_MAX = 4: d_req held continuously (reissued after each ack), i_req held -> exactly 4 d_acks, then 1 i_ack, then data resumes; dcnt returns to 0 after the fetch grant.
- Reset mid-access: assert rst for one cycle while in ACC of a load -> no ack emitted; next cycle busy = 0, mem_we = 0; a reissued request completes normally.
- Hold-through-ack: the requester keeps req high during its ack cycle, then drops it -> only one ack and one RAM access recorded.
